// File: rtl/wb_bridge_pkg.sv
// wb_bridge_pkg: shared FSM type and constants for the N-way Wishbone bridge
package wb_bridge_pkg;
  localparam int MAX_PORTS = 8;
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder: combinational base/mask decoder, lowest matching port wins
module wb_addr_decoder
  import wb_bridge_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter logic [NUM_PORTS*32-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_PORTS*32-1:0] ADDR_MASKS = '0,
  parameter int IDX_W = idx_width(NUM_PORTS)
) (
  input  logic [31:0]      adr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);
  // scan downwards so the lowest matching index is the one left standing
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((adr_i & ADDR_MASKS[i*32 +: 32]) == (BASE_ADDRS[i*32 +: 32] & ADDR_MASKS[i*32 +: 32])) begin
        hit_o = 1'b1;
        idx_o = i[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/wb_bridge_nway.sv
// wb_bridge_nway: one-outstanding Wishbone splitter to NUM_PORTS windows with timeout
module wb_bridge_nway
  import wb_bridge_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_ADDR_WIDTH = 11,
  parameter logic [NUM_PORTS*32-1:0] BASE_ADDRS = {32'h3000_3000, 32'h3000_2000, 32'h3000_1000, 32'h3000_0000},
  parameter logic [NUM_PORTS*32-1:0] ADDR_MASKS = {4{32'hFFFF_F000}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic [31:0]                wbs_dat_o,
  output logic [NUM_PORTS-1:0]       wbm_stb_o,
  output logic [NUM_PORTS-1:0]       wbm_cyc_o,
  output logic                       wbm_we_o,
  output logic [3:0]                 wbm_sel_o,
  output logic [31:0]                wbm_dat_o,
  output logic [PORT_ADDR_WIDTH-1:0] wbm_adr_o,
  input  logic [NUM_PORTS-1:0]       wbm_ack_i,
  input  logic [NUM_PORTS*32-1:0]    wbm_dat_i,
  output logic [7:0]                 timeout_count_o
);
  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_e state_q, state_d;
  logic [IDX_W-1:0] port_q, port_d, hit_idx;
  logic hit, we_q, we_d, err_q, err_d;
  logic [3:0] sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [PORT_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;

  wb_addr_decoder #(
    .NUM_PORTS (NUM_PORTS),
    .BASE_ADDRS(BASE_ADDRS),
    .ADDR_MASKS(ADDR_MASKS),
    .IDX_W     (IDX_W)
  ) u_dec (
    .adr_i(wbs_adr_i),
    .hit_o(hit),
    .idx_o(hit_idx)
  );

  assign wbm_stb_o = (state_q == ST_BUSY) ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << port_q) : '0;
  assign wbm_cyc_o = wbm_stb_o;
  assign wbm_we_o = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_dat_o = wdat_q;
  assign wbm_adr_o = adr_q;
  assign wbs_ack_o = (state_q == ST_RESP) && !err_q;
  assign wbs_err_o = (state_q == ST_RESP) && err_q;
  assign wbs_dat_o = rdat_q;
  assign timeout_count_o = tmo_q;

  // next state: accept/decode in IDLE, wait for ack/abort/timeout in BUSY, one response cycle
  always_comb begin
    state_d = state_q;
    port_d = port_q;
    we_d = we_q;
    sel_d = sel_q;
    wdat_d = wdat_q;
    adr_d = adr_q;
    rdat_d = rdat_q;
    err_d = err_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    case (state_q)
      ST_IDLE:
        if (wbs_cyc_i && wbs_stb_i) begin
          if (hit) begin
            state_d = ST_BUSY;
            port_d = hit_idx;
            we_d = wbs_we_i;
            sel_d = wbs_sel_i;
            wdat_d = wbs_dat_i;
            adr_d = wbs_adr_i[PORT_ADDR_WIDTH-1:0];
            cnt_d = '0;
          end else begin
            state_d = ST_RESP;
            err_d = 1'b1;
            rdat_d = ERR_DATA;
          end
        end
      ST_BUSY:
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wbm_ack_i[port_q]) begin
          state_d = ST_RESP;
          err_d = 1'b0;
          rdat_d = wbm_dat_i[port_q*32 +: 32];
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RESP;
          err_d = 1'b1;
          rdat_d = ERR_DATA;
          tmo_d = tmo_q + {7'd0, tmo_q != 8'hFF};
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      port_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      wdat_q <= '0;
      adr_q <= '0;
      rdat_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      we_q <= we_d;
      sel_q <= sel_d;
      wdat_q <= wdat_d;
      adr_q <= adr_d;
      rdat_q <= rdat_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
endmodule

// File: tb/tb_wb_bridge_nway.sv
// tb_wb_bridge_nway: randomized transaction-level model check of the N-way bridge
module tb_wb_bridge_nway;
  localparam int T = 4;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;

  logic stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] wdat = 0, adr = 0;
  logic ack_o, err_o;
  logic [31:0] dat_o;
  logic [3:0] m_stb, m_cyc, m_sel;
  logic m_we;
  logic [31:0] m_dat;
  logic [10:0] m_adr;
  logic [3:0] m_ack = 0;
  logic [127:0] m_dat_i = 0;
  logic [7:0] tmo_o;

  logic b_ack_o, b_err_o, b_we;
  logic [31:0] b_dat_o, b_mdat;
  logic [2:0] b_stb, b_cyc;
  logic [3:0] b_sel;
  logic [10:0] b_madr;
  logic [7:0] b_tmo;

  wb_bridge_nway #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
    .wbs_ack_o(ack_o), .wbs_err_o(err_o), .wbs_dat_o(dat_o),
    .wbm_stb_o(m_stb), .wbm_cyc_o(m_cyc), .wbm_we_o(m_we), .wbm_sel_o(m_sel), .wbm_dat_o(m_dat),
    .wbm_adr_o(m_adr), .wbm_ack_i(m_ack), .wbm_dat_i(m_dat_i), .timeout_count_o(tmo_o)
  );

  // overlapping-window instance: ports 0 and 2 share 0x3000_0000/0xFFFF_0000
  wb_bridge_nway #(
    .NUM_PORTS(3),
    .BASE_ADDRS({32'h3000_0000, 32'h3000_1000, 32'h3000_0000}),
    .ADDR_MASKS({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES(T)
  ) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
    .wbs_ack_o(b_ack_o), .wbs_err_o(b_err_o), .wbs_dat_o(b_dat_o),
    .wbm_stb_o(b_stb), .wbm_cyc_o(b_cyc), .wbm_we_o(b_we), .wbm_sel_o(b_sel), .wbm_dat_o(b_mdat),
    .wbm_adr_o(b_madr), .wbm_ack_i(m_ack[2:0]), .wbm_dat_i(m_dat_i[95:0]), .timeout_count_o(b_tmo)
  );

  int errors = 0, checks = 0;
  bit check_en = 0, use_fix = 0;
  logic [3:0] fix_mask = 0;

  // behavioural model state: what the bridge has latched / returned so far
  logic [31:0] last_rdat = 0, lat_dat = 0;
  logic lat_we = 0;
  logic [3:0] lat_sel = 0;
  logic [10:0] lat_adr = 0;
  int mtmo = 0;

  logic [3:0] exp_stb = 0;
  logic exp_ack = 0, exp_err = 0, exp_we = 0;
  logic [3:0] exp_sel = 0;
  logic [31:0] exp_dat = 0, exp_mdat = 0;
  logic [10:0] exp_adr = 0;
  logic [7:0] exp_tmo = 0;

  logic [3:0] a_stb_seen = 0;
  logic [2:0] b_stb_seen = 0;
  int a_stb_cycles = 0, a_ack_n = 0, a_err_n = 0, b_ack_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare every cycle mid-period against the model's expectation
  always @(negedge clk) begin
    if (check_en) begin
      chk("wbm_stb", 32'(m_stb), 32'(exp_stb));
      chk("wbm_cyc", 32'(m_cyc), 32'(exp_stb));
      chk("wbs_ack", 32'(ack_o), 32'(exp_ack));
      chk("wbs_err", 32'(err_o), 32'(exp_err));
      chk("wbs_dat", dat_o, exp_dat);
      chk("wbm_we", 32'(m_we), 32'(exp_we));
      chk("wbm_sel", 32'(m_sel), 32'(exp_sel));
      chk("wbm_dat", m_dat, exp_mdat);
      chk("wbm_adr", 32'(m_adr), 32'(exp_adr));
      chk("timeout_count", 32'(tmo_o), 32'(exp_tmo));
      if (ack_o && err_o) chk("ack_err_excl", 32'(1), 32'(0));
    end
    a_stb_seen |= m_stb;
    b_stb_seen |= b_stb;
    a_stb_cycles += (m_stb != 0) ? 1 : 0;
    a_ack_n += ack_o ? 1 : 0;
    a_err_n += err_o ? 1 : 0;
    b_ack_n += b_ack_o ? 1 : 0;
  end

  task automatic clear_mon();
    a_stb_seen = 0; b_stb_seen = 0; a_stb_cycles = 0; a_ack_n = 0; a_err_n = 0; b_ack_n = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [3:0] s, input logic a, input logic e);
    exp_stb = s; exp_ack = a; exp_err = e; exp_dat = last_rdat;
    exp_we = lat_we; exp_sel = lat_sel; exp_mdat = lat_dat; exp_adr = lat_adr; exp_tmo = 8'(mtmo);
  endtask

  function automatic logic [3:0] noise();
    return use_fix ? fix_mask : 4'($urandom);
  endfunction

  // four 4 KiB windows starting at 0x3000_0000, one per port
  function automatic int decode(input logic [31:0] a);
    logic [31:0] off;
    off = (a >> 12) - 32'h0003_0000;
    return (off < 4) ? int'(off) : -1;
  endfunction

  task automatic idle(input int n);
    cyc = 0; stb = 0;
    for (int i = 0; i < n; i++) begin
      m_ack = noise();
      set_exp(0, 0, 0);
      tick();
    end
  endtask

  // one upstream transaction; ack_at/drop_at are 1-based BUSY cycle numbers, 0 = never
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                         input int ack_at, input int drop_at, input logic [31:0] ack_dat);
    int p, last;
    logic [3:0] pm;
    bit aborted, acked;
    p = decode(a);
    adr = a; we = w; sel = s; wdat = d; cyc = 1; stb = 1;
    m_ack = noise(); m_dat_i = {$urandom, $urandom, $urandom, $urandom};
    set_exp(0, 0, 0);
    tick();
    if (p < 0) begin
      last_rdat = 0;
      m_ack = noise();
      set_exp(0, 0, 1);
      tick();
      cyc = 0; stb = 0;
      return;
    end
    lat_we = w; lat_sel = s; lat_dat = d; lat_adr = a[10:0];
    pm = 4'b0001 << p;
    last = T;
    if (ack_at >= 1 && ack_at < last) last = ack_at;
    if (drop_at >= 1 && drop_at < last) last = drop_at;
    aborted = (drop_at == last);
    acked = !aborted && (ack_at == last);
    for (int b = 1; b <= last; b++) begin
      set_exp(pm, 0, 0);
      m_ack = noise() & ~pm;
      m_dat_i = {$urandom, $urandom, $urandom, $urandom};
      if (b == ack_at) begin
        m_ack = m_ack | pm;
        m_dat_i[p*32 +: 32] = ack_dat;
      end
      if (b == drop_at) begin
        cyc = 0; stb = 0;
      end
      tick();
    end
    m_ack = noise();
    if (aborted) set_exp(0, 0, 0);
    else begin
      if (acked) last_rdat = ack_dat;
      else begin
        last_rdat = 0;
        if (mtmo < 255) mtmo++;
      end
      set_exp(0, acked, !acked);
    end
    tick();
    cyc = 0; stb = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb"}, 32'(m_stb), 0);
    chk({tag, "_cyc"}, 32'(m_cyc), 0);
    chk({tag, "_ack"}, 32'(ack_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_dat"}, dat_o, 0);
    chk({tag, "_adr"}, 32'(m_adr), 0);
    chk({tag, "_sel"}, 32'(m_sel), 0);
    chk({tag, "_we"}, 32'(m_we), 0);
    chk({tag, "_mdat"}, m_dat, 0);
    chk({tag, "_tmo"}, 32'(tmo_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int k, ack_at, drop_at;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    set_exp(0, 0, 0);
    check_en = 1;
    rst_n = 1;
    idle(1);

    // overlapping windows: port 0 wins, the port-2 ack is ignored
    clear_mon();
    use_fix = 1; fix_mask = 4'b0100;
    run_txn(32'h3000_0004, 0, 4'hF, 0, 2, 0, 32'hC0DE_0032);
    use_fix = 0;
    chk("ovl_b_stb_seen", 32'(b_stb_seen), 32'h1);
    chk("ovl_b_ack_n", b_ack_n, 1);
    chk("ovl_b_dat", b_dat_o, 32'hC0DE_0032);
    idle(1);

    clear_mon();
    run_txn(32'h3000_1004, 0, 4'hF, 0, 3, 0, 32'hA5A5_0001);
    chk("rd_adr", 32'(m_adr), 32'h004);
    chk("rd_dat", dat_o, 32'hA5A5_0001);
    chk("rd_busy_cycles", a_stb_cycles, 3);
    chk("rd_ack_n", a_ack_n, 1);
    chk("rd_port", 32'(a_stb_seen), 32'h2);

    clear_mon();
    run_txn(32'h3000_3010, 1, 4'b0011, 32'h1234_5678, 2, 0, $urandom);
    chk("wr_port", 32'(a_stb_seen), 32'h8);
    chk("wr_mdat", m_dat, 32'h1234_5678);
    chk("wr_sel", 32'(m_sel), 32'h3);
    chk("wr_adr", 32'(m_adr), 32'h010);
    chk("wr_we", 32'(m_we), 1);

    clear_mon();
    run_txn(32'h3000_9000, 0, 4'hF, 0, 1, 0, $urandom);
    chk("unmap_stb", 32'(a_stb_seen), 0);
    chk("unmap_err_n", a_err_n, 1);
    chk("unmap_ack_n", a_ack_n, 0);
    chk("unmap_dat", dat_o, 0);

    clear_mon();
    run_txn(32'h3000_0020, 0, 4'hF, 0, 0, 0, 0);
    chk("tmo_first", 32'(tmo_o), 1);
    chk("tmo_busy_cycles", a_stb_cycles, T);
    chk("tmo_err_n", a_err_n, 1);

    clear_mon();
    run_txn(32'h3000_2040, 0, 4'hF, 0, T, 0, 32'h0BAD_F00D);
    chk("ack_beats_tmo_ack", a_ack_n, 1);
    chk("ack_beats_tmo_err", a_err_n, 0);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      if (k < 8) a = 32'h3000_0000 + ($urandom_range(0, 3) << 12) + $urandom_range(0, 32'hFFF);
      else if (k == 8) a = 32'h3000_4000 + $urandom_range(0, 32'hFFFF);
      else a = $urandom;
      ack_at = $urandom_range(0, 6);
      drop_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, ack_at, drop_at, $urandom);
      idle($urandom_range(0, 2));
    end

    for (int n = 0; n < 300; n++) run_txn(32'h3000_0000 + $urandom_range(0, 32'hFFF), 0, 4'hF, 0, 0, 0, 0);
    chk("tmo_saturate", 32'(tmo_o), 255);

    clear_mon();
    run_txn(32'h3000_1008, 1, 4'hF, 32'hDEAD_BEEF, 0, 2, 0);
    chk("abort_ack_n", a_ack_n, 0);
    chk("abort_err_n", a_err_n, 0);
    chk("abort_busy_cycles", a_stb_cycles, 2);
    idle(1);

    adr = 32'h3000_2000; we = 0; sel = 4'hF; wdat = 32'h7777_0000; cyc = 1; stb = 1; m_ack = 0;
    set_exp(0, 0, 0);
    tick();
    lat_we = 0; lat_sel = 4'hF; lat_dat = 32'h7777_0000; lat_adr = 11'h000;
    set_exp(4'b0100, 0, 0);
    tick();
    set_exp(4'b0100, 0, 0);
    chk("pre_rst_stb", 32'(m_stb), 32'h4);
    #1 rst_n = 0;
    last_rdat = 0; lat_we = 0; lat_sel = 0; lat_dat = 0; lat_adr = 0; mtmo = 0;
    set_exp(0, 0, 0);
    cyc = 0; stb = 0;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    rst_n = 1;
    clear_mon();
    run_txn(32'h3000_3004, 0, 4'hF, 0, 1, 0, 32'h5555_AAAA);
    chk("post_rst_dat", dat_o, 32'h5555_AAAA);
    chk("post_rst_ack_n", a_ack_n, 1);
    idle(2);
    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
